// File: rtl/gt_event_detector_if.sv
// ============================================================================
//  Module      : gt_event_detector_if
//  Description : Sample/qualify bus between the greater-than comparator side
//                and the gt_event_detector qualifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gt_event_detector_if #(
    parameter int EVENT_CNT_WIDTH = 8
) ();
    logic                       i_valid;
    logic                       i_A_greater_than_B;
    logic                       i_clear_count;
    logic                       o_active;
    logic                       o_rise;
    logic                       o_fall;
    logic [EVENT_CNT_WIDTH-1:0] o_event_count;

    // Producer side: drives samples and clear, observes qualified results
    modport master (
        output i_valid,
        output i_A_greater_than_B,
        output i_clear_count,
        input  o_active,
        input  o_rise,
        input  o_fall,
        input  o_event_count
    );

    // Qualifier side
    modport slave (
        input  i_valid,
        input  i_A_greater_than_B,
        input  i_clear_count,
        output o_active,
        output o_rise,
        output o_fall,
        output o_event_count
    );
endinterface

`default_nettype wire

// File: rtl/gt_event_detector.sv
// ============================================================================
//  Module      : gt_event_detector
//  Description : Hysteresis qualifier for the A>B comparator result. Enters
//                ACTIVE after ASSERT_COUNT consecutive true samples, leaves
//                after DEASSERT_COUNT consecutive false samples, and reports
//                registered rise/fall pulses plus a saturating rise count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gt_event_detector #(
    parameter int ASSERT_COUNT    = 3,
    parameter int DEASSERT_COUNT  = 2,
    parameter int EVENT_CNT_WIDTH = 8
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    gt_event_detector_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMING    = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_RELEASING = 2'd3
    } state_t;

    localparam logic [7:0]                 c_assert_cnt   = 8'(ASSERT_COUNT);
    localparam logic [7:0]                 c_deassert_cnt = 8'(DEASSERT_COUNT);
    localparam logic [EVENT_CNT_WIDTH-1:0] c_cnt_one      = EVENT_CNT_WIDTH'(1);
    localparam logic [EVENT_CNT_WIDTH-1:0] c_cnt_max      = '1;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [7:0]                 r_run;
    logic [7:0]                 w_run_next;
    logic [7:0]                 w_run_inc;
    logic                       w_rise_next;
    logic                       w_fall_next;
    logic                       w_active_next;
    logic                       r_active;
    logic                       r_rise;
    logic                       r_fall;
    logic [EVENT_CNT_WIDTH-1:0] r_count;

    assign w_run_inc = r_run + 8'd1;

    // Next-state, run counter and edge-pulse decode; invalid edges hold everything
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        w_rise_next  = 1'b0;
        w_fall_next  = 1'b0;
        if (bus.i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_A_greater_than_B) begin
                        if (c_assert_cnt == 8'd1) begin
                            w_state_next = ST_ACTIVE;
                            w_rise_next  = 1'b1;
                        end else begin
                            w_state_next = ST_ARMING;
                            w_run_next   = 8'd1;
                        end
                    end
                end
                ST_ARMING: begin
                    if (bus.i_A_greater_than_B) begin
                        if (w_run_inc == c_assert_cnt) begin
                            w_state_next = ST_ACTIVE;
                            w_rise_next  = 1'b1;
                            w_run_next   = 8'd0;
                        end else begin
                            w_run_next   = w_run_inc;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                        w_run_next   = 8'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.i_A_greater_than_B) begin
                        if (c_deassert_cnt == 8'd1) begin
                            w_state_next = ST_IDLE;
                            w_fall_next  = 1'b1;
                        end else begin
                            w_state_next = ST_RELEASING;
                            w_run_next   = 8'd1;
                        end
                    end
                end
                ST_RELEASING: begin
                    if (!bus.i_A_greater_than_B) begin
                        if (w_run_inc == c_deassert_cnt) begin
                            w_state_next = ST_IDLE;
                            w_fall_next  = 1'b1;
                            w_run_next   = 8'd0;
                        end else begin
                            w_run_next   = w_run_inc;
                        end
                    end else begin
                        w_state_next = ST_ACTIVE;
                        w_run_next   = 8'd0;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_run_next   = 8'd0;
                end
            endcase
        end
        w_active_next = (w_state_next == ST_ACTIVE) || (w_state_next == ST_RELEASING);
    end

    // State, run counter and registered outputs; reset discards any partial run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_run    <= 8'd0;
            r_active <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_run    <= w_run_next;
            r_active <= w_active_next;
            r_rise   <= w_rise_next;
            r_fall   <= w_fall_next;
        end
    end

    // Saturating rise counter; a clear coinciding with a rise leaves a count of one
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (bus.i_clear_count) begin
            r_count <= w_rise_next ? c_cnt_one : '0;
        end else if (w_rise_next && (r_count != c_cnt_max)) begin
            r_count <= r_count + c_cnt_one;
        end
    end

    assign bus.o_active      = r_active;
    assign bus.o_rise        = r_rise;
    assign bus.o_fall        = r_fall;
    assign bus.o_event_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_gt_event_detector.sv
// ============================================================================
//  Module      : tb_gt_event_detector
//  Description : Directed self-checking bench for gt_event_detector. A default
//                instance covers qualify/release/clear/reset; a 2-bit counter
//                instance with unit counts covers saturation and back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gt_event_detector;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    gt_event_detector_if #(.EVENT_CNT_WIDTH(8)) bus_a ();
    gt_event_detector_if #(.EVENT_CNT_WIDTH(2)) bus_s ();

    gt_event_detector #(
        .ASSERT_COUNT    (3),
        .DEASSERT_COUNT  (2),
        .EVENT_CNT_WIDTH (8)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    gt_event_detector #(
        .ASSERT_COUNT    (1),
        .DEASSERT_COUNT  (1),
        .EVENT_CNT_WIDTH (2)
    ) u_sat (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One edge on the default instance with the given inputs
    task automatic drive_a(input logic v, input logic gt, input logic clr);
        bus_a.i_valid            = v;
        bus_a.i_A_greater_than_B = gt;
        bus_a.i_clear_count      = clr;
        tick();
        bus_a.i_clear_count      = 1'b0;
    endtask

    // Drive the default instance from ACTIVE back to IDLE (two false samples)
    task automatic release_a();
        drive_a(1'b1, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0);
    endtask

    // Full qualify on the default instance (three true samples)
    task automatic qualify_a();
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++; if (bus_a.o_active !== 1'b0) $display("FAIL reset_active got %b want 0", bus_a.o_active); else n_pass++;
        n_checks++; if (bus_a.o_rise !== 1'b0) $display("FAIL reset_rise got %b want 0", bus_a.o_rise); else n_pass++;
        n_checks++; if (bus_a.o_fall !== 1'b0) $display("FAIL reset_fall got %b want 0", bus_a.o_fall); else n_pass++;
        n_checks++; if (bus_a.o_event_count !== 8'd0) $display("FAIL reset_count got %0d want 0", bus_a.o_event_count); else n_pass++;
        n_checks++; if (bus_s.o_event_count !== 2'd0) $display("FAIL reset_sat_count got %0d want 0", bus_s.o_event_count); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_qualify();
        logic [5:0] gt_seq;
        logic [5:0] exp_rise;
        gt_seq   = 6'b111011;   // bit 0 first: 1,1,0,1,1,1
        exp_rise = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            drive_a(1'b1, gt_seq[i], 1'b0);
            n_checks++;
            if (bus_a.o_rise !== exp_rise[i]) $display("FAIL qualify_rise_s%0d got %b want %b", i + 1, bus_a.o_rise, exp_rise[i]); else n_pass++;
            n_checks++;
            if (bus_a.o_active !== exp_rise[i]) $display("FAIL qualify_active_s%0d got %b want %b", i + 1, bus_a.o_active, exp_rise[i]); else n_pass++;
        end
        n_checks++; if (bus_a.o_event_count !== 8'd1) $display("FAIL qualify_count got %0d want 1", bus_a.o_event_count); else n_pass++;
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus_a.o_rise !== 1'b0) $display("FAIL qualify_rise_drop got %b want 0", bus_a.o_rise); else n_pass++;
        n_checks++; if (bus_a.o_active !== 1'b1) $display("FAIL qualify_active_hold got %b want 1", bus_a.o_active); else n_pass++;
    endtask

    task automatic test_hysteresis_release();
        logic [3:0] gt_seq;
        logic [3:0] exp_active;
        logic [3:0] exp_fall;
        gt_seq     = 4'b0010;   // bit 0 first: 0,1,0,0
        exp_active = 4'b0111;
        exp_fall   = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, gt_seq[i], 1'b0);
            n_checks++;
            if (bus_a.o_active !== exp_active[i]) $display("FAIL release_active_s%0d got %b want %b", i + 1, bus_a.o_active, exp_active[i]); else n_pass++;
            n_checks++;
            if (bus_a.o_fall !== exp_fall[i]) $display("FAIL release_fall_s%0d got %b want %b", i + 1, bus_a.o_fall, exp_fall[i]); else n_pass++;
        end
        drive_a(1'b0, 1'b0, 1'b0);
        n_checks++; if (bus_a.o_fall !== 1'b0) $display("FAIL release_fall_drop got %b want 0", bus_a.o_fall); else n_pass++;
    endtask

    task automatic test_valid_gaps();
        logic [5:0] v_seq;
        logic [5:0] exp_rise;
        v_seq    = 6'b101001;   // bit 0 first: 1,0,0,1,0,1
        exp_rise = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            drive_a(v_seq[i], 1'b1, 1'b0);
            n_checks++;
            if (bus_a.o_rise !== exp_rise[i]) $display("FAIL gaps_rise_e%0d got %b want %b", i + 1, bus_a.o_rise, exp_rise[i]); else n_pass++;
            n_checks++;
            if (bus_a.o_active !== exp_rise[i]) $display("FAIL gaps_active_e%0d got %b want %b", i + 1, bus_a.o_active, exp_rise[i]); else n_pass++;
        end
        n_checks++; if (bus_a.o_event_count !== 8'd2) $display("FAIL gaps_count got %0d want 2", bus_a.o_event_count); else n_pass++;
    endtask

    task automatic test_clear_collision();
        for (int i = 0; i < 3; i++) begin
            release_a();
            qualify_a();
        end
        n_checks++; if (bus_a.o_event_count !== 8'd5) $display("FAIL clear_pre_count got %0d want 5", bus_a.o_event_count); else n_pass++;
        release_a();
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1);
        n_checks++; if (bus_a.o_rise !== 1'b1) $display("FAIL clear_rise got %b want 1", bus_a.o_rise); else n_pass++;
        n_checks++; if (bus_a.o_event_count !== 8'd1) $display("FAIL clear_collide_count got %0d want 1", bus_a.o_event_count); else n_pass++;
        drive_a(1'b0, 1'b0, 1'b1);
        n_checks++; if (bus_a.o_event_count !== 8'd0) $display("FAIL clear_alone_count got %0d want 0", bus_a.o_event_count); else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) begin
            release_a();
            qualify_a();
        end
        n_checks++; if (bus_a.o_event_count !== 8'd4) $display("FAIL areset_pre_count got %0d want 4", bus_a.o_event_count); else n_pass++;
        drive_a(1'b1, 1'b0, 1'b0);   // ACTIVE -> RELEASING
        n_checks++; if (bus_a.o_active !== 1'b1) $display("FAIL areset_releasing_active got %b want 1", bus_a.o_active); else n_pass++;
        bus_a.i_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (bus_a.o_active !== 1'b0) $display("FAIL areset_active got %b want 0", bus_a.o_active); else n_pass++;
        n_checks++; if (bus_a.o_fall !== 1'b0) $display("FAIL areset_fall got %b want 0", bus_a.o_fall); else n_pass++;
        n_checks++; if (bus_a.o_rise !== 1'b0) $display("FAIL areset_rise got %b want 0", bus_a.o_rise); else n_pass++;
        n_checks++; if (bus_a.o_event_count !== 8'd0) $display("FAIL areset_count got %0d want 0", bus_a.o_event_count); else n_pass++;
        #1;
        rst = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus_a.o_fall !== 1'b0) $display("FAIL areset_post_fall got %b want 0", bus_a.o_fall); else n_pass++;
        n_checks++; if (bus_a.o_rise !== 1'b0) $display("FAIL areset_post_rise1 got %b want 0", bus_a.o_rise); else n_pass++;
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus_a.o_rise !== 1'b0) $display("FAIL areset_post_rise2 got %b want 0", bus_a.o_rise); else n_pass++;
        drive_a(1'b1, 1'b1, 1'b0);
        n_checks++; if (bus_a.o_rise !== 1'b1) $display("FAIL areset_post_rise3 got %b want 1", bus_a.o_rise); else n_pass++;
        n_checks++; if (bus_a.o_event_count !== 8'd1) $display("FAIL areset_post_count got %0d want 1", bus_a.o_event_count); else n_pass++;
    endtask

    task automatic test_back_to_back_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus_s.i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus_s.i_A_greater_than_B = 1'b1;
            tick();
            n_checks++;
            if (bus_s.o_rise !== 1'b1 || bus_s.o_fall !== 1'b0) $display("FAIL sat_rise_p%0d got rise=%b fall=%b want rise=1 fall=0", i + 1, bus_s.o_rise, bus_s.o_fall); else n_pass++;
            n_checks++;
            if (bus_s.o_event_count !== exp_cnt[i]) $display("FAIL sat_count_p%0d got %0d want %0d", i + 1, bus_s.o_event_count, exp_cnt[i]); else n_pass++;
            bus_s.i_A_greater_than_B = 1'b0;
            tick();
            n_checks++;
            if (bus_s.o_fall !== 1'b1 || bus_s.o_rise !== 1'b0 || bus_s.o_active !== 1'b0) $display("FAIL sat_fall_p%0d got fall=%b rise=%b active=%b want 1 0 0", i + 1, bus_s.o_fall, bus_s.o_rise, bus_s.o_active); else n_pass++;
        end
        bus_s.i_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        bus_a.i_valid = 1'b0; bus_a.i_A_greater_than_B = 1'b0; bus_a.i_clear_count = 1'b0;
        bus_s.i_valid = 1'b0; bus_s.i_A_greater_than_B = 1'b0; bus_s.i_clear_count = 1'b0;
        test_reset();
        test_basic_qualify();
        test_hysteresis_release();
        test_valid_gaps();
        test_clear_collision();
        test_async_reset();
        test_back_to_back_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
